// File: rtl/leds_racer_input_hub.sv
// Per-player button front end: synchronise, debounce, press-edge detect, and a per-frame
// press accumulator that is snapshotted on every update_frame strobe.
module leds_racer_input_hub #(
    parameter int unsigned NUM_PLAYERS      = 4,
    parameter int unsigned DEBOUNCE_CLK_CNT = 65536,
    parameter int unsigned EVT_CNT_W        = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PLAYERS-1:0]           btn_in,
    input  logic                             update_frame,
    output logic [NUM_PLAYERS-1:0]           btn_level,
    output logic [NUM_PLAYERS-1:0]           press_pulse,
    output logic [NUM_PLAYERS-1:0]           frame_press,
    output logic [NUM_PLAYERS*EVT_CNT_W-1:0] frame_press_count,
    output logic [NUM_PLAYERS-1:0]           frame_overflow
);

    localparam int unsigned CNT_W = (DEBOUNCE_CLK_CNT > 1) ? $clog2(DEBOUNCE_CLK_CNT) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CLK_CNT - 1);
    localparam logic [EVT_CNT_W-1:0] ACC_MAX = '1;

    logic [NUM_PLAYERS-1:0] sync1_q, sync2_q;
    logic [NUM_PLAYERS-1:0] level_q, level_d;
    logic [NUM_PLAYERS-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0]       cnt_q [NUM_PLAYERS];
    logic [CNT_W-1:0]       cnt_d [NUM_PLAYERS];
    logic [EVT_CNT_W-1:0]   acc_q [NUM_PLAYERS];
    logic [EVT_CNT_W-1:0]   acc_d [NUM_PLAYERS];
    logic [EVT_CNT_W-1:0]   acc_inc [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] ovf_q, ovf_d, ovf_inc;
    logic [NUM_PLAYERS-1:0] fpress_q, fpress_d;
    logic [EVT_CNT_W-1:0]   fcnt_q [NUM_PLAYERS];
    logic [EVT_CNT_W-1:0]   fcnt_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] fovf_q, fovf_d;

    always_comb begin
        level_d  = level_q;
        pulse_d  = '0;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        acc_inc  = acc_q;
        ovf_d    = ovf_q;
        ovf_inc  = ovf_q;
        fpress_d = fpress_q;
        fcnt_d   = fcnt_q;
        fovf_d   = fovf_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                cnt_d[i]   = '0;
                level_d[i] = sync2_q[i];
                pulse_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // Fold this cycle's pulse in first so a press on the strobe lands in the snapshot.
            if (pulse_q[i]) begin
                if (acc_q[i] == ACC_MAX) begin
                    ovf_inc[i] = 1'b1;
                end else begin
                    acc_inc[i] = acc_q[i] + EVT_CNT_W'(1);
                end
            end

            if (update_frame) begin
                fcnt_d[i]   = acc_inc[i];
                fpress_d[i] = (acc_inc[i] != '0);
                fovf_d[i]   = ovf_inc[i];
                acc_d[i]    = '0;
                ovf_d[i]    = 1'b0;
            end else begin
                acc_d[i] = acc_inc[i];
                ovf_d[i] = ovf_inc[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            pulse_q  <= '0;
            ovf_q    <= '0;
            fpress_q <= '0;
            fovf_q   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                cnt_q[i]  <= '0;
                acc_q[i]  <= '0;
                fcnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            ovf_q    <= ovf_d;
            fpress_q <= fpress_d;
            fovf_q   <= fovf_d;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                acc_q[i]  <= acc_d[i];
                fcnt_q[i] <= fcnt_d[i];
            end
        end
    end

    always_comb begin
        frame_press_count = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            frame_press_count[i*EVT_CNT_W +: EVT_CNT_W] = fcnt_q[i];
        end
    end

    assign btn_level      = level_q;
    assign press_pulse    = pulse_q;
    assign frame_press    = fpress_q;
    assign frame_overflow = fovf_q;

endmodule
